// File: rtl/seven_seg_scan.sv
// Scan controller for a 4-digit common-anode display: one digit per slot,
// per-frame input snapshot, anti-ghost blanking and leading-zero blanking.
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  hex,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned     CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      s_val_q, s_val_d;
    logic [3:0]       s_dp_q, s_dp_d;
    logic [3:0]       s_en_q, s_en_d;
    logic             s_lz_q, s_lz_d;

    logic slot_end;
    logic past_blank;
    logic lzb;
    logic vis;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_tick = slot_end && (idx_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        s_val_d = s_val_q;
        s_dp_d  = s_dp_q;
        s_en_d  = s_en_q;
        s_lz_d  = s_lz_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        // Snapshot on the frame's last edge so a frame never mixes old and new data
        if (frame_tick) begin
            s_val_d = value;
            s_dp_d  = dp_in;
            s_en_d  = digit_en;
            s_lz_d  = lz_blank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            s_val_q <= '0;
            s_dp_q  <= '0;
            s_en_q  <= '0;
            s_lz_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            s_val_q <= s_val_d;
            s_dp_q  <= s_dp_d;
            s_en_q  <= s_en_d;
            s_lz_q  <= s_lz_d;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt_q >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        hex = s_val_q[3:0];
        lzb = 1'b0;
        case (idx_q)
            2'd0: begin
                hex = s_val_q[3:0];
                lzb = 1'b0;
            end
            2'd1: begin
                hex = s_val_q[7:4];
                lzb = s_lz_q && (s_val_q[15:4] == 12'h000);
            end
            2'd2: begin
                hex = s_val_q[11:8];
                lzb = s_lz_q && (s_val_q[15:8] == 8'h00);
            end
            default: begin
                hex = s_val_q[15:12];
                lzb = s_lz_q && (s_val_q[15:12] == 4'h0);
            end
        endcase
    end

    assign dp  = ~s_dp_q[idx_q];
    assign vis = s_en_q[idx_q] && !lzb && past_blank;
    assign an  = vis ? ~(4'b0001 << idx_q) : 4'b1111;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: main instance at REFRESH_DIV=8/BLANK_CYCLES=2,
// second instance at REFRESH_DIV=2/BLANK_CYCLES=0.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;

    logic [3:0]  hex, an;
    logic        dp, frame_tick;
    logic [3:0]  hex2, an2;
    logic        dp2, frame_tick2;

    int unsigned total  = 0;
    int unsigned passed = 0;

    seven_seg_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank),
        .hex(hex), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    seven_seg_scan #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank),
        .hex(hex2), .dp(dp2), .an(an2), .frame_tick(frame_tick2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // At most one anode may be driven at any time, on either instance
    always @(negedge clk) begin
        check("an_onehot", {3'b000, ($countones(~an) <= 1)}, 4'b0001);
        check("an2_onehot", {3'b000, ($countones(~an2) <= 1)}, 4'b0001);
    end

    task automatic check_slot(input int unsigned slot, input logic [3:0] exp_hex,
                              input logic exp_dp, input logic [3:0] exp_an,
                              input int unsigned ncyc);
        for (int unsigned k = 0; k < ncyc; k++) begin
            check($sformatf("hex s%0d k%0d", slot, k), hex, exp_hex);
            check($sformatf("dp s%0d k%0d", slot, k), {3'b000, dp}, {3'b000, exp_dp});
            check($sformatf("an s%0d k%0d", slot, k), an, (k < 2) ? 4'b1111 : exp_an);
            check($sformatf("frame_tick s%0d k%0d", slot, k), {3'b000, frame_tick},
                  {3'b000, (slot == 3 && k == 7)});
            tick();
        end
    endtask

    task automatic dark_frame(input string tag);
        for (int unsigned c = 0; c < 32; c++) begin
            check($sformatf("%s an c%0d", tag, c), an, 4'b1111);
            check($sformatf("%s hex c%0d", tag, c), hex, 4'h0);
            check($sformatf("%s dp c%0d", tag, c), {3'b000, dp}, 4'b0001);
            check($sformatf("%s frame_tick c%0d", tag, c), {3'b000, frame_tick},
                  {3'b000, (c == 31)});
            tick();
        end
    endtask

    logic [3:0] an2_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] hex2_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        reset    = 1'b1;
        value    = 16'h1234;
        dp_in    = 4'b0000;
        digit_en = 4'hF;
        lz_blank = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        dark_frame("boot");

        // 1234 across all slots
        check_slot(0, 4'h4, 1'b1, 4'b1110, 8);
        check_slot(1, 4'h3, 1'b1, 4'b1101, 8);
        check_slot(2, 4'h2, 1'b1, 4'b1011, 8);
        check_slot(3, 4'h1, 1'b1, 4'b0111, 8);

        // Mid-frame value change does not tear the current frame
        check_slot(0, 4'h4, 1'b1, 4'b1110, 8);
        value = 16'hBEEF;
        check_slot(1, 4'h3, 1'b1, 4'b1101, 8);
        check_slot(2, 4'h2, 1'b1, 4'b1011, 8);
        check_slot(3, 4'h1, 1'b1, 4'b0111, 8);

        check_slot(0, 4'hF, 1'b1, 4'b1110, 8);
        dp_in    = 4'b0100;
        digit_en = 4'b1011;
        check_slot(1, 4'hE, 1'b1, 4'b1101, 8);
        check_slot(2, 4'hE, 1'b1, 4'b1011, 8);
        check_slot(3, 4'hB, 1'b1, 4'b0111, 8);

        // Decimal point on digit 2 while digit 2 is disabled
        check_slot(0, 4'hF, 1'b1, 4'b1110, 8);
        value    = 16'h0000;
        lz_blank = 1'b1;
        dp_in    = 4'b0000;
        digit_en = 4'hF;
        check_slot(1, 4'hE, 1'b1, 4'b1101, 8);
        check_slot(2, 4'hE, 1'b0, 4'b1111, 8);
        check_slot(3, 4'hB, 1'b1, 4'b0111, 8);

        // Leading-zero blanking: all-zero value keeps digit 0 only
        check_slot(0, 4'h0, 1'b1, 4'b1110, 8);
        value = 16'h0305;
        check_slot(1, 4'h0, 1'b1, 4'b1111, 8);
        check_slot(2, 4'h0, 1'b1, 4'b1111, 8);
        check_slot(3, 4'h0, 1'b1, 4'b1111, 8);

        // 0305: only digit 3 blanked, embedded zero on digit 1 is shown
        check_slot(0, 4'h5, 1'b1, 4'b1110, 8);
        check_slot(1, 4'h0, 1'b1, 4'b1101, 8);
        check_slot(2, 4'h3, 1'b1, 4'b1011, 8);
        check_slot(3, 4'h0, 1'b1, 4'b1111, 8);

        // Reset at idx=2, cnt=5
        check_slot(0, 4'h5, 1'b1, 4'b1110, 8);
        check_slot(1, 4'h0, 1'b1, 4'b1101, 8);
        check_slot(2, 4'h3, 1'b1, 4'b1011, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dark_frame("midrst");
        check_slot(0, 4'h5, 1'b1, 4'b1110, 8);
        check_slot(1, 4'h0, 1'b1, 4'b1101, 8);
        check_slot(2, 4'h3, 1'b1, 4'b1011, 8);
        check_slot(3, 4'h0, 1'b1, 4'b1111, 8);

        // Second instance: 2-cycle slots, no blanking gap
        value    = 16'h1234;
        lz_blank = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        for (int unsigned c = 0; c < 24; c++) begin
            check($sformatf("an2 c%0d", c), an2, (c < 8) ? 4'b1111 : an2_tab[(c / 2) % 4]);
            check($sformatf("hex2 c%0d", c), hex2, (c < 8) ? 4'h0 : hex2_tab[(c / 2) % 4]);
            check($sformatf("dp2 c%0d", c), {3'b000, dp2}, 4'b0001);
            check($sformatf("frame_tick2 c%0d", c), {3'b000, frame_tick2},
                  {3'b000, (c % 8 == 7)});
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
